// File: rtl/rf_pkg.sv
// Shared defaults and helpers for the 2-write / 2-read register file with scoreboard.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
//   Contents: WIDTH/DEPTH defaults, address-width derivation, default-width data/address types.
package rf_pkg;

    localparam int RF_WIDTH = 16;
    localparam int RF_DEPTH = 16;

    // Address width for a given register count. DEPTH is a power of two >= 2,
    // so the result is always at least 1.
    function automatic int rf_aw(input int depth);
        return $clog2(depth);
    endfunction

    typedef logic [RF_WIDTH-1:0]          data_t;
    typedef logic [rf_aw(RF_DEPTH)-1:0]   addr_t;

endpackage

// File: rtl/reg_file_2w2r_sb_if.sv
// Bundle of the register file's write, reserve and read signals.
// Latency: n/a (wiring only).
// Backpressure: none; A_rdy/B_rdy report operand readiness, not flow control.
//   Ports (master drives): write0/DA0/D0, write1/DA1/D1, reserve/RA, AA/BA
//   Ports (slave drives):  A/B, A_rdy/B_rdy, pend, regs
interface reg_file_2w2r_sb_if
    import rf_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH,
    parameter int DEPTH = RF_DEPTH
);
    localparam int AW = rf_aw(DEPTH);

    logic                   write0;
    logic [AW-1:0]          DA0;
    logic [WIDTH-1:0]       D0;
    logic                   write1;
    logic [AW-1:0]          DA1;
    logic [WIDTH-1:0]       D1;
    logic                   reserve;
    logic [AW-1:0]          RA;
    logic [AW-1:0]          AA;
    logic [AW-1:0]          BA;
    logic [WIDTH-1:0]       A;
    logic [WIDTH-1:0]       B;
    logic                   A_rdy;
    logic                   B_rdy;
    logic [DEPTH-1:0]       pend;
    logic [DEPTH*WIDTH-1:0] regs;

    modport master (
        output write0, DA0, D0, write1, DA1, D1, reserve, RA, AA, BA,
        input  A, B, A_rdy, B_rdy, pend, regs
    );

    modport slave (
        input  write0, DA0, D0, write1, DA1, D1, reserve, RA, AA, BA,
        output A, B, A_rdy, B_rdy, pend, regs
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by reserve, cleared by writeback.
// Latency: set/clear take effect at the next rising edge; rdy lookups are combinational.
// Backpressure: none; reserve and clears are always accepted.
//   Ports: i_clk, i_rst_n, i_clr0_vld/i_clr0_addr, i_clr1_vld/i_clr1_addr,
//          i_set_vld/i_set_addr, i_rd_a_addr, i_rd_b_addr -> o_pend, o_a_rdy, o_b_rdy
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter  int DEPTH = RF_DEPTH,
    localparam int AW    = rf_aw(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr0_vld,
    input  logic [AW-1:0]    i_clr0_addr,
    input  logic             i_clr1_vld,
    input  logic [AW-1:0]    i_clr1_addr,
    input  logic             i_set_vld,
    input  logic [AW-1:0]    i_set_addr,
    input  logic [AW-1:0]    i_rd_a_addr,
    input  logic [AW-1:0]    i_rd_b_addr,
    output logic [DEPTH-1:0] o_pend,
    output logic             o_a_rdy,
    output logic             o_b_rdy
);

    logic [DEPTH-1:0] r_pend;
    logic [DEPTH-1:0] w_pend_nxt;

    // A reserve landing on the same edge as a writeback belongs to a newer
    // producer, so set beats clear.
    always_comb begin
        w_pend_nxt = r_pend;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_set_vld && (i_set_addr == AW'(i))) begin
                w_pend_nxt[i] = 1'b1;
            end else if ((i_clr0_vld && (i_clr0_addr == AW'(i))) ||
                         (i_clr1_vld && (i_clr1_addr == AW'(i)))) begin
                w_pend_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    assign o_pend  = r_pend;
    assign o_a_rdy = ~r_pend[i_rd_a_addr];
    assign o_b_rdy = ~r_pend[i_rd_b_addr];

endmodule

// File: rtl/reg_file_2w2r_sb.sv
// WIDTH x DEPTH register file, two write ports (port 1 wins on same address), two
//   combinational read ports and a pending-write scoreboard.
// Latency: writes visible one cycle after the edge; reads combinational. Backpressure: none.
//   Ports: clock, reset (async active-low), bus (slave modport of reg_file_2w2r_sb_if).
//   Optional build macro RF_BYPASS_EN: reads matching an active write return that write's
//   data and report ready in the same cycle; stored contents and regs are unaffected.
module reg_file_2w2r_sb
    import rf_pkg::*;
#(
    parameter int WIDTH   = RF_WIDTH,
    parameter int DEPTH   = RF_DEPTH,
    parameter int ZERO_R0 = 0
) (
    input  logic              clock,
    input  logic              reset,
    reg_file_2w2r_sb_if.slave bus
);

    localparam int AW = rf_aw(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_z0_en;
    logic             w_we0;
    logic             w_we1;
    logic             w_rsv;
    logic             w_sb_a_rdy;
    logic             w_sb_b_rdy;
    logic [WIDTH-1:0] w_a_dat;
    logic [WIDTH-1:0] w_b_dat;
    logic             w_a_rdy;
    logic             w_b_rdy;

    assign w_z0_en = (ZERO_R0 != 0);

    // With ZERO_R0 every access to register 0 is masked here, so r_mem[0] stays
    // at its reset value of 0 and pend[0] is never set; reads need no special case.
    assign w_we1 = bus.write1 && !(w_z0_en && (bus.DA1 == '0));
    assign w_we0 = bus.write0 && !(w_z0_en && (bus.DA0 == '0)) &&
                   !(bus.write1 && (bus.DA1 == bus.DA0));
    assign w_rsv = bus.reserve && !(w_z0_en && (bus.RA == '0));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_we0) begin
                r_mem[bus.DA0] <= bus.D0;
            end
            if (w_we1) begin
                r_mem[bus.DA1] <= bus.D1;
            end
        end
    end

    // A port-0 write dropped by a same-address collision still has port 1
    // clearing that register, so the masked enables are correct clear sources.
    rf_scoreboard #(
        .DEPTH (DEPTH)
    ) u_sb (
        .i_clk       (clock),
        .i_rst_n     (reset),
        .i_clr0_vld  (w_we0),
        .i_clr0_addr (bus.DA0),
        .i_clr1_vld  (w_we1),
        .i_clr1_addr (bus.DA1),
        .i_set_vld   (w_rsv),
        .i_set_addr  (bus.RA),
        .i_rd_a_addr (bus.AA),
        .i_rd_b_addr (bus.BA),
        .o_pend      (bus.pend),
        .o_a_rdy     (w_sb_a_rdy),
        .o_b_rdy     (w_sb_b_rdy)
    );

`ifdef RF_BYPASS_EN
    // Port 1 is checked first so it wins when both ports target the read address.
    always_comb begin
        w_a_dat = r_mem[bus.AA];
        w_a_rdy = w_sb_a_rdy;
        if (w_we1 && (bus.DA1 == bus.AA)) begin
            w_a_dat = bus.D1;
            w_a_rdy = 1'b1;
        end else if (w_we0 && (bus.DA0 == bus.AA)) begin
            w_a_dat = bus.D0;
            w_a_rdy = 1'b1;
        end
    end

    always_comb begin
        w_b_dat = r_mem[bus.BA];
        w_b_rdy = w_sb_b_rdy;
        if (w_we1 && (bus.DA1 == bus.BA)) begin
            w_b_dat = bus.D1;
            w_b_rdy = 1'b1;
        end else if (w_we0 && (bus.DA0 == bus.BA)) begin
            w_b_dat = bus.D0;
            w_b_rdy = 1'b1;
        end
    end
`else
    assign w_a_dat = r_mem[bus.AA];
    assign w_b_dat = r_mem[bus.BA];
    assign w_a_rdy = w_sb_a_rdy;
    assign w_b_rdy = w_sb_b_rdy;
`endif

    assign bus.A     = w_a_dat;
    assign bus.B     = w_b_dat;
    assign bus.A_rdy = w_a_rdy;
    assign bus.B_rdy = w_b_rdy;

    for (genvar g = 0; g < DEPTH; g++) begin : g_dump
        assign bus.regs[g*WIDTH +: WIDTH] = r_mem[g];
    end

endmodule

// File: tb/tb_reg_file_2w2r_sb.sv
// Directed bench for reg_file_2w2r_sb: one instance with ZERO_R0=0, one with ZERO_R0=1.
// Latency: n/a. Backpressure: n/a.
//   Inputs change on the falling edge; outputs are checked away from the rising edge.
module tb_reg_file_2w2r_sb;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    reg_file_2w2r_sb_if #(.WIDTH(16), .DEPTH(16)) bus0 ();
    reg_file_2w2r_sb_if #(.WIDTH(16), .DEPTH(16)) bus1 ();

    reg_file_2w2r_sb #(.WIDTH(16), .DEPTH(16), .ZERO_R0(0)) dut0 (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus0)
    );

    reg_file_2w2r_sb #(.WIDTH(16), .DEPTH(16), .ZERO_R0(1)) dut1 (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle0();
        bus0.write0 = 1'b0; bus0.DA0 = '0; bus0.D0 = '0;
        bus0.write1 = 1'b0; bus0.DA1 = '0; bus0.D1 = '0;
        bus0.reserve = 1'b0; bus0.RA = '0;
    endtask

    task automatic idle1();
        bus1.write0 = 1'b0; bus1.DA0 = '0; bus1.D0 = '0;
        bus1.write1 = 1'b0; bus1.DA1 = '0; bus1.D1 = '0;
        bus1.reserve = 1'b0; bus1.RA = '0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle0(); idle1();
        bus0.AA = '0; bus0.BA = '0;
        bus1.AA = '0; bus1.BA = '0;
        rst_n = 1'b1;

        // Reset low at 2ns, released at 7ns.
        #2 rst_n = 1'b0;
        #2;
        check("rst_hold_pend", 256'(bus0.pend), 256'(16'h0000));
        check("rst_hold_regs", bus0.regs, 256'd0);
        #3 rst_n = 1'b1;
        #1;
        check("rst_regs", bus0.regs, 256'd0);
        check("rst_pend", 256'(bus0.pend), 256'(16'h0000));
        check("rst_a_rdy", 256'(bus0.A_rdy), 256'(1'b1));
        check("rst_b_rdy", 256'(bus0.B_rdy), 256'(1'b1));
        check("rst_a", 256'(bus0.A), 256'(16'h0000));
        check("rst_z_pend", 256'(bus1.pend), 256'(16'h0000));

        // Single write, read back the following cycle.
        @(negedge clk);
        bus0.write0 = 1'b1; bus0.DA0 = 4'd3; bus0.D0 = 16'hBEEF; bus0.AA = 4'd3;
        #1;
`ifdef RF_BYPASS_EN
        check("wr3_same_cycle", 256'(bus0.A), 256'(16'hBEEF));
`else
        check("wr3_same_cycle", 256'(bus0.A), 256'(16'h0000));
`endif
        @(negedge clk);
        idle0();
        #1;
        check("wr3_a", 256'(bus0.A), 256'(16'hBEEF));
        check("wr3_regs", 256'(bus0.regs[3*16 +: 16]), 256'(16'hBEEF));

        // Same-address double write: port 1 wins.
        @(negedge clk);
        bus0.write0 = 1'b1; bus0.DA0 = 4'd5; bus0.D0 = 16'h1111;
        bus0.write1 = 1'b1; bus0.DA1 = 4'd5; bus0.D1 = 16'h2222;
        bus0.BA = 4'd5;
        #1;
`ifdef RF_BYPASS_EN
        check("dup5_same_cycle", 256'(bus0.B), 256'(16'h2222));
`else
        check("dup5_same_cycle", 256'(bus0.B), 256'(16'h0000));
`endif
        @(negedge clk);
        idle0();
        #1;
        check("dup5_regs", 256'(bus0.regs[5*16 +: 16]), 256'(16'h2222));
        check("dup5_b", 256'(bus0.B), 256'(16'h2222));

        // Different-address double write, both read ports on the same register.
        @(negedge clk);
        bus0.write0 = 1'b1; bus0.DA0 = 4'd1; bus0.D0 = 16'h0101;
        bus0.write1 = 1'b1; bus0.DA1 = 4'd2; bus0.D1 = 16'h0202;
        @(negedge clk);
        idle0();
        bus0.AA = 4'd2; bus0.BA = 4'd2;
        #1;
        check("dual_r1", 256'(bus0.regs[1*16 +: 16]), 256'(16'h0101));
        check("dual_r2", 256'(bus0.regs[2*16 +: 16]), 256'(16'h0202));
        check("same_addr_a", 256'(bus0.A), 256'(16'h0202));
        check("same_addr_b", 256'(bus0.B), 256'(16'h0202));

        // Reserve 7, then retire it with a port-1 write.
        @(negedge clk);
        bus0.reserve = 1'b1; bus0.RA = 4'd7; bus0.AA = 4'd7; bus0.BA = 4'd5;
        @(negedge clk);
        idle0();
        #1;
        check("rsv7_pend", 256'(bus0.pend), 256'(16'h0080));
        check("rsv7_a_rdy", 256'(bus0.A_rdy), 256'(1'b0));
        check("rsv7_b_rdy", 256'(bus0.B_rdy), 256'(1'b1));
        @(negedge clk);
        bus0.write1 = 1'b1; bus0.DA1 = 4'd7; bus0.D1 = 16'h7777;
        #1;
`ifdef RF_BYPASS_EN
        check("wb7_same_rdy", 256'(bus0.A_rdy), 256'(1'b1));
`else
        check("wb7_same_rdy", 256'(bus0.A_rdy), 256'(1'b0));
`endif
        @(negedge clk);
        idle0();
        #1;
        check("wb7_pend", 256'(bus0.pend), 256'(16'h0000));
        check("wb7_a_rdy", 256'(bus0.A_rdy), 256'(1'b1));
        check("wb7_a", 256'(bus0.A), 256'(16'h7777));

        // Reserve and write to 9 on the same edge: reservation survives, data lands.
        @(negedge clk);
        bus0.reserve = 1'b1; bus0.RA = 4'd9;
        bus0.write0 = 1'b1; bus0.DA0 = 4'd9; bus0.D0 = 16'h9999;
        bus0.AA = 4'd9;
        @(negedge clk);
        idle0();
        #1;
        check("rw9_pend", 256'(bus0.pend), 256'(16'h0200));
        check("rw9_regs", 256'(bus0.regs[9*16 +: 16]), 256'(16'h9999));
        check("rw9_a_rdy", 256'(bus0.A_rdy), 256'(1'b0));

        // Re-reserving an already pending register keeps it pending.
        @(negedge clk);
        bus0.reserve = 1'b1; bus0.RA = 4'd9;
        @(negedge clk);
        idle0();
        #1;
        check("rerr9_pend", 256'(bus0.pend), 256'(16'h0200));

        // ZERO_R0 instance: register 0 ignores writes and reserves; others work.
        @(negedge clk);
        bus1.write0 = 1'b1; bus1.DA0 = 4'd0; bus1.D0 = 16'hFFFF;
        bus1.reserve = 1'b1; bus1.RA = 4'd0;
        bus1.write1 = 1'b1; bus1.DA1 = 4'd1; bus1.D1 = 16'hABCD;
        bus1.AA = 4'd0; bus1.BA = 4'd1;
        #1;
        check("z0_same_cycle_a", 256'(bus1.A), 256'(16'h0000));
        @(negedge clk);
        idle1();
        #1;
        check("z0_a", 256'(bus1.A), 256'(16'h0000));
        check("z0_a_rdy", 256'(bus1.A_rdy), 256'(1'b1));
        check("z0_pend", 256'(bus1.pend), 256'(16'h0000));
        check("z0_regs0", 256'(bus1.regs[15:0]), 256'(16'h0000));
        check("z0_r1_b", 256'(bus1.B), 256'(16'hABCD));

        // Reset mid-cycle with a write and reserve in flight.
        @(negedge clk);
        bus0.reserve = 1'b1; bus0.RA = 4'd4;
        bus0.write0 = 1'b1; bus0.DA0 = 4'd4; bus0.D0 = 16'h4444;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_pend", 256'(bus0.pend), 256'(16'h0000));
        check("mid_rst_regs", bus0.regs, 256'd0);
        idle0();
        #1 rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_pend", 256'(bus0.pend), 256'(16'h0000));
        check("post_rst_regs", bus0.regs, 256'd0);
        check("post_rst_z_regs", bus1.regs, 256'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
